mem_dump_unit: RTL

Debug-path consumer of the data memory. On a start pulse after program halt, it walks data memory from address 0 to DUMP_DEPTH-1. It reads each word with the memory's 1-cycle registered read and serialises the word MSB-byte-first into a byte transmitter (UART TX) through a start/done handshake. It owns the memory address and write-enable while busy; the CPU-side mux selects it via busy.

---
 rtl/mem_dump_unit_pkg.sv | 21 ++
 rtl/mem_dump_unit_word_serializer.sv | 48 ++++
 rtl/mem_dump_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_dump_unit_pkg.sv
// rtl/mem_dump_unit_pkg.sv - shared constants for the data-memory dump unit
// FSM encodings, memory geometry defaults and the bytes-per-word helper.
package mem_dump_unit_pkg;

  localparam int DEF_RAM_WIDTH     = 16;
  localparam int DEF_RAM_ADDR_BITS = 11;
  localparam int DEF_DUMP_DEPTH    = 128;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR    = 3'd1;
  localparam logic [2:0] ST_LATCH   = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_WAIT_TX = 3'd4;
  localparam logic [2:0] ST_NEXT    = 3'd5;
  localparam logic [2:0] ST_CHKSUM  = 3'd6;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/mem_dump_unit_word_serializer.sv
// rtl/mem_dump_unit_word_serializer.sv - word shift register emitting bytes MSB first
// Loads a memory word, exposes its top byte and flags when the last byte is showing.
module mem_dump_unit_word_serializer
  import mem_dump_unit_pkg::*;
#(
  parameter int RAM_WIDTH = DEF_RAM_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift,
  input  logic [RAM_WIDTH-1:0] din,
  output logic [7:0]           byte_out,
  output logic                 last
);

  localparam int BPW   = bytes_per_word(RAM_WIDTH);
  localparam int IDX_W = $clog2(BPW) + 1;

  logic [RAM_WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (load) begin
      shreg_d = din;
      idx_d   = '0;
    end else if (shift) begin
      shreg_d = shreg_q << 8;
      idx_d   = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign byte_out = shreg_q[RAM_WIDTH-1 -: 8];
  assign last     = (idx_q == IDX_W'(BPW - 1));

endmodule

// File: rtl/mem_dump_unit.sv
// rtl/mem_dump_unit.sv - walks data memory and streams each word bytewise to a UART TX
// Define MEM_DUMP_CHECKSUM_EN to append an XOR checksum byte after the data.
module mem_dump_unit
  import mem_dump_unit_pkg::*;
#(
  parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
  parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
  parameter int DUMP_DEPTH    = DEF_DUMP_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic                     mem_write,
  input  logic [RAM_WIDTH-1:0]     mem_rdata,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_done,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W = RAM_ADDR_BITS + 1;

  logic [2:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [RAM_ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic                     tx_start_q, tx_start_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0]               chk_q, chk_d;
  logic                     chk_phase_q, chk_phase_d;
`endif

  logic       ser_load, ser_shift, ser_last;
  logic [7:0] ser_byte;

  mem_dump_unit_word_serializer #(.RAM_WIDTH(RAM_WIDTH)) u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (ser_load),
    .shift    (ser_shift),
    .din      (mem_rdata),
    .byte_out (ser_byte),
    .last     (ser_last)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
    chk_d       = chk_q;
    chk_phase_d = chk_phase_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          mem_addr_d = '0;
          cnt_d      = '0;
          state_d    = ST_ADDR;
`ifdef MEM_DUMP_CHECKSUM_EN
          chk_d       = '0;
          chk_phase_d = 1'b0;
`endif
        end
      end
      ST_ADDR:  state_d = ST_LATCH;
      ST_LATCH: begin
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        tx_data_d  = ser_byte;
        tx_start_d = 1'b1;
        state_d    = ST_WAIT_TX;
`ifdef MEM_DUMP_CHECKSUM_EN
        chk_d = chk_q ^ ser_byte;
`endif
      end
      ST_WAIT_TX: begin
        // a tx_done coincident with our own tx_start belongs to an earlier byte
        if (tx_done && !tx_start_q) begin
`ifdef MEM_DUMP_CHECKSUM_EN
          if (chk_phase_q) begin
            chk_phase_d = 1'b0;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
          end else
`endif
          if (ser_last) begin
            state_d = ST_NEXT;
          end else begin
            ser_shift = 1'b1;
            state_d   = ST_SEND;
          end
        end
      end
      ST_NEXT: begin
        if (cnt_q == CNT_W'(DUMP_DEPTH - 1)) begin
`ifdef MEM_DUMP_CHECKSUM_EN
          state_d = ST_CHKSUM;
`else
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          mem_addr_d = mem_addr_q + RAM_ADDR_BITS'(1);
          state_d    = ST_ADDR;
        end
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      ST_CHKSUM: begin
        tx_data_d   = chk_q;
        tx_start_d  = 1'b1;
        chk_phase_d = 1'b1;
        state_d     = ST_WAIT_TX;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      chk_q       <= '0;
      chk_phase_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef MEM_DUMP_CHECKSUM_EN
      chk_q       <= chk_d;
      chk_phase_q <= chk_phase_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_write = 1'b0;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
